// File: rtl/plab3_mem_wben_merge_buffer.sv
// Write-combining buffer: merges partial stores to one line and security domain
// into a single line-wide write with per-byte enables, draining on change, full or flush.
module plab3_mem_wben_merge_buffer #(
    parameter int unsigned p_line_nbytes = 16,
    parameter int unsigned p_addr_nbits  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic [p_addr_nbits-1:0]      in_addr,
    input  logic [31:0]                  in_data,
    input  logic [1:0]                   in_len,
    input  logic                         in_sd,
    input  logic                         flush,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [p_addr_nbits-1:0]      out_addr,
    output logic [8*p_line_nbytes-1:0]   out_data,
    output logic [p_line_nbytes-1:0]     out_wben,
    output logic                         out_sd,
    output logic                         busy
);

    localparam int unsigned c_off_nbits  = $clog2(p_line_nbytes);
    localparam int unsigned c_tag_nbits  = p_addr_nbits - c_off_nbits;
    localparam int unsigned c_data_nbits = 8 * p_line_nbytes;

    typedef enum logic [1:0] {StEmpty, StMerge, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [c_tag_nbits-1:0]    tag_q, tag_d;
    logic                      sd_q, sd_d;
    logic [p_line_nbytes-1:0]  wben_q, wben_d;
    logic [c_data_nbits-1:0]   data_q, data_d;

    logic [c_off_nbits-1:0]    req_off;
    logic [c_tag_nbits-1:0]    req_tag;
    logic [2:0]                req_n;
    logic [3:0]                len_mask;
    logic [31:0]               data_m;
    logic [p_line_nbytes-1:0]  req_mask;
    logic [c_data_nbits-1:0]   req_data;
    logic [c_data_nbits-1:0]   req_bmask;
    logic [c_off_nbits+1:0]    req_end;
    logic                      req_cross;
    logic                      match;
    logic [p_line_nbytes-1:0]  merge_wben;
    logic [c_data_nbits-1:0]   merge_data;

    assign req_off = in_addr[c_off_nbits-1:0];
    assign req_tag = in_addr[p_addr_nbits-1:c_off_nbits];
    assign req_n   = (in_len == 2'd0) ? 3'd4 : {1'b0, in_len};

    always_comb begin
        unique case (in_len)
            2'd1:    len_mask = 4'b0001;
            2'd2:    len_mask = 4'b0011;
            2'd3:    len_mask = 4'b0111;
            default: len_mask = 4'b1111;
        endcase
    end

    // Bytes past the end of the line are shifted out and never written.
    assign data_m   = in_data & {{8{len_mask[3]}}, {8{len_mask[2]}},
                                 {8{len_mask[1]}}, {8{len_mask[0]}}};
    assign req_mask = p_line_nbytes'(len_mask) << req_off;
    assign req_data = c_data_nbits'(data_m) << {req_off, 3'b000};

    assign req_end   = (c_off_nbits + 2)'(req_off) + (c_off_nbits + 2)'(req_n);
    assign req_cross = req_end > (c_off_nbits + 2)'(p_line_nbytes);

    always_comb begin
        req_bmask = '0;
        for (int k = 0; k < p_line_nbytes; k++) begin
            req_bmask[8*k +: 8] = {8{req_mask[k]}};
        end
    end

    assign match      = (tag_q == req_tag) && (sd_q == in_sd);
    assign merge_wben = wben_q | req_mask;
    assign merge_data = (data_q & ~req_bmask) | req_data;

    always_comb begin
        unique case (state_q)
            StEmpty: in_rdy = 1'b1;
            StMerge: in_rdy = in_val && match && !flush;
            default: in_rdy = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        sd_d    = sd_q;
        wben_d  = wben_q;
        data_d  = data_q;
        unique case (state_q)
            StEmpty: begin
                if (in_val) begin
                    tag_d   = req_tag;
                    sd_d    = in_sd;
                    wben_d  = req_mask;
                    data_d  = req_data;
                    state_d = (&req_mask) ? StDrain : StMerge;
                end
            end
            StMerge: begin
                // Flush wins over a same-cycle matching store; a mismatch drains and
                // leaves the store pending for the next empty cycle.
                if (flush) begin
                    state_d = StDrain;
                end else if (in_val && match) begin
                    wben_d = merge_wben;
                    data_d = merge_data;
                    if (&merge_wben) begin
                        state_d = StDrain;
                    end
                end else if (in_val) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_rdy) begin
                    state_d = StEmpty;
                    wben_d  = '0;
                    data_d  = '0;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            tag_q   <= '0;
            sd_q    <= 1'b0;
            wben_q  <= '0;
            data_q  <= '0;
        end else begin
            if (in_val && in_rdy) begin
                assert (!req_cross);
            end
            state_q <= state_d;
            tag_q   <= tag_d;
            sd_q    <= sd_d;
            wben_q  <= wben_d;
            data_q  <= data_d;
        end
    end

    assign out_val  = (state_q == StDrain);
    assign busy     = (state_q != StEmpty);
    assign out_addr = {tag_q, {c_off_nbits{1'b0}}};
    assign out_data = data_q;
    assign out_wben = wben_q;
    assign out_sd   = sd_q;

endmodule

// File: doc/plab3_mem_wben_merge_buffer.md
Name: plab3_mem_wben_merge_buffer

Overview:
- Domain-tagged write-combining buffer placed between the processor store path and the memory/cache write port.
- Decodes each partial store (address, length) into a per-byte write-enable mask and merges successive stores to the same line and security domain into one line-wide write.
- Drains the line on a line/domain change, a full mask or an explicit flush.
- Never combines data from two security domains in one line.

Parameters:
- p_line_nbytes, 16, bytes per merged line; power of two, >= 4.
- p_addr_nbits, 32, address width.
- c_off_nbits, log2(p_line_nbytes), byte-offset width (local, not set externally).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_val  input  1  store request valid
- in_rdy  output  1  store request accepted when in_val && in_rdy
- in_addr  input  p_addr_nbits  byte address
- in_data  input  32  store data, little-endian, byte 0 in [7:0]
- in_len  input  2  bytes to write; 0 means 4
- in_sd  input  1  security domain of the request
- flush  input  1  force drain of the buffered line
- out_val  output  1  merged line valid
- out_rdy  input  1  downstream accepts line
- out_addr  output  p_addr_nbits  line-aligned address (offset bits zero)
- out_data  output  8*p_line_nbytes  line data; byte k in [8k+7:8k]
- out_wben  output  p_line_nbytes  byte enables; bit k = byte k written
- out_sd  output  1  domain of the buffered line
- busy  output  1  state != EMPTY

Behaviour:
- Reset: synchronous, clk and reset only, active-high. State=EMPTY. Tag, sd, wben and data registers cleared to 0. out_val=0, in_rdy=1 in the next cycle. Reset in any state drops the buffered line with no output.
- Decode: off = in_addr[c_off_nbits-1:0]; n = (in_len==0) ? 4 : in_len.
  - Request mask bit k = 1 iff off <= k < off+n.
  - Data byte j goes to line byte off+j.
  - Bytes with off+j >= p_line_nbytes are masked off; a vc-assert fires when a request crosses the line.
- Match: in_addr tag (bits above the offset) equals the stored tag, and in_sd equals the stored sd.
- EMPTY: in_rdy=1, out_val=0. On accept:
  - Load tag, sd, mask and placed data.
  - Next state is DRAIN if the mask is all ones, else MERGE.
  - flush in EMPTY is ignored.
- MERGE: in_rdy = in_val && match && !flush.
  - On accept: wben |= mask; data bytes with mask=1 are overwritten, others are held. Later store wins.
  - If the resulting wben is all ones, go to DRAIN.
  - flush=1 goes to DRAIN. Flush has priority over a same-cycle merge; the request is not accepted.
  - in_val && !match: in_rdy=0, go to DRAIN. The request stays pending and is accepted from EMPTY after the drain.
- DRAIN: out_val=1, in_rdy=0.
  - out_addr, out_data, out_wben and out_sd come straight from registers and are stable while out_val && !out_rdy.
  - On out_rdy: go to EMPTY, clear wben and data to 0 (no stale bytes carried into the next domain or line).
- Latency:
  - Accepted store to out_val is 1 cycle minimum (full-mask case).
  - A drain handshake in cycle t allows a new accept in cycle t+1. There is no same-cycle drain-and-accept bypass.
- Bytes with wben=0 in out_data are always 0.
- out_* is driven from registers only; there is no combinational path from in_* to out_*.
- out_val has no combinational dependence on out_rdy.

Test Plan:
- Single word then flush. Store 0x104, len 0, data 0xAABBCCDD, sd 0; then flush=1 → out_addr=0x100, out_wben=0x00F0, out_data[63:32]=0xAABBCCDD, all other bits 0, out_sd=0.
- Auto-drain on full. Word stores to 0x200, 0x204, 0x208, 0x20C, back-to-back with no stalls → out_val asserts the cycle after the 4th accept, out_wben=0xFFFF, no flush needed, in_rdy=0 while draining.
- Domain change.
  - Store 0x301, len 1, data 0x11, sd 0; then 0x301, len 1, data 0x22, sd 1.
  - Second request held (in_rdy=0) while the first line drains: out_wben=0x0002, byte1=0x11, out_sd=0.
  - Then second line drains on flush: byte1=0x22, out_sd=1.
- Overwrite merge. Store 0x400, len 0, data 0x11223344; then 0x401, len 2, data 0x0000BEEF; then flush → out_wben=0x000F, out_data[31:0]=0x11BEEF44.
- Backpressure and reset.
  - In DRAIN with out_rdy=0 for 5 cycles: out_val=1 and all out_* unchanged each cycle.
  - Assert reset in cycle 3 → next cycle out_val=0, busy=0, in_rdy=1; a following flush produces no output.
- Line change, same domain. Store 0x500 then 0x510, both sd 0 → line 0x500 (wben 0x000F) drains first; 0x510 accepted the cycle after the drain handshake; simultaneous flush+matching in_val → request not accepted, drain occurs.
